// File: rtl/fifo_inst_encoder_pkg.sv
// Shared definitions for the 34-bit FIFO instruction interface.
package fifo_inst_encoder_pkg;

   localparam int INST_W = 34;
   localparam int DATA_W = 32;
   localparam int WE_BIT = 33;
   localparam int RE_BIT = 32;

   // Instruction word as seen on the FIFO port: {WE, RE, DI}.
   typedef struct packed {
      logic              we;
      logic              re;
      logic [DATA_W-1:0] di;
   } inst_t;

   // Build an instruction word from its fields.
   function automatic inst_t make_inst(input logic we, input logic re, input logic [DATA_W-1:0] di);
      inst_t w_inst;
      w_inst.we = we;
      w_inst.re = re;
      w_inst.di = di;
      return w_inst;
   endfunction

endpackage

// File: rtl/fifo_inst_encoder_occ_tracker.sv
// Occupancy / outstanding-read bookkeeping for the FIFO instruction initiator.
module fifo_occ_tracker
   import fifo_inst_encoder_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_acc,
   input  logic             i_rd_acc,
   input  logic             i_read_valid,
   output logic [OCC_W-1:0] o_occ,
   output logic [OCC_W-1:0] o_outst,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_err
);

   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] ZERO_C  = {OCC_W{1'b0}};
   localparam logic [OCC_W-1:0] ONE_C   = {{(OCC_W-1){1'b0}}, 1'b1};

   logic [OCC_W-1:0] r_occ;
   logic [OCC_W-1:0] r_outst;
   logic             r_err;
   logic [OCC_W-1:0] w_occ_next;
   logic [OCC_W-1:0] w_outst_next;
   logic             w_ret;

   // A return only retires a read when one is actually outstanding.
   assign w_ret = i_read_valid && (r_outst != ZERO_C);

   // Next occupancy: push adds, pop subtracts, both or neither hold.
   always_comb begin
      w_occ_next = r_occ;
      case ({i_wr_acc, i_rd_acc})
         2'b10:   w_occ_next = r_occ + ONE_C;
         2'b01:   w_occ_next = r_occ - ONE_C;
         default: w_occ_next = r_occ;
      endcase
   end

   // Next outstanding count: issued reads add, returned reads retire.
   always_comb begin
      w_outst_next = r_outst;
      case ({i_rd_acc, w_ret})
         2'b10:   w_outst_next = r_outst + ONE_C;
         2'b01:   w_outst_next = r_outst - ONE_C;
         default: w_outst_next = r_outst;
      endcase
   end

   // Counter and sticky-error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ   <= ZERO_C;
         r_outst <= ZERO_C;
         r_err   <= 1'b0;
      end else begin
         r_occ   <= w_occ_next;
         r_outst <= w_outst_next;
         if (i_read_valid && (r_outst == ZERO_C)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_occ   = r_occ;
   assign o_outst = r_outst;
   assign o_full  = (r_occ == DEPTH_C);
   assign o_empty = (r_occ == ZERO_C);
   assign o_err   = r_err;

endmodule

// File: rtl/fifo_inst_encoder.sv
// Initiator side of the FIFO instruction interface: accepts writes and read
// requests, emits one registered {WE, RE, DI} word per cycle and collects
// returned read data.
module fifo_inst_encoder
   import fifo_inst_encoder_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_req,
   output logic              rd_ready,
   output logic [INST_W-1:0] inst,
   input  logic [DATA_W-1:0] fifo_do,
   input  logic              fifo_read_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   output logic [OCC_W-1:0]  occupancy,
   output logic [OCC_W-1:0]  outstanding,
   output logic              full,
   output logic              empty,
   output logic              err_unexpected
);

   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] ZERO_C  = {OCC_W{1'b0}};

   inst_t             r_inst;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_data_valid;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [OCC_W-1:0]  w_occ;

   // Acceptance is decided from registered occupancy only, so a write never
   // counts on a same-cycle pop and a read never counts on write-through.
   assign wr_ready = (w_occ < DEPTH_C);
   assign rd_ready = (w_occ > ZERO_C);
   assign w_wr_acc = wr_valid && wr_ready;
   assign w_rd_acc = rd_req && rd_ready;

   fifo_occ_tracker #(
      .DEPTH (DEPTH),
      .OCC_W (OCC_W)
   ) u_occ_tracker (
      .clk          (clk),
      .rst          (rst),
      .i_wr_acc     (w_wr_acc),
      .i_rd_acc     (w_rd_acc),
      .i_read_valid (fifo_read_valid),
      .o_occ        (w_occ),
      .o_outst      (outstanding),
      .o_full       (full),
      .o_empty      (empty),
      .o_err        (err_unexpected)
   );

   // Encode stage: WE/RE follow acceptance, DI keeps its last written value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst <= make_inst(1'b0, 1'b0, {DATA_W{1'b0}});
      end else if (w_wr_acc) begin
         r_inst <= make_inst(1'b1, w_rd_acc, wr_data);
      end else begin
         r_inst <= make_inst(1'b0, w_rd_acc, r_inst.di);
      end
   end

   // Return path: one-cycle registered copy of the FIFO read data strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data       <= {DATA_W{1'b0}};
         r_rd_data_valid <= 1'b0;
      end else begin
         r_rd_data_valid <= fifo_read_valid;
         if (fifo_read_valid) begin
            r_rd_data <= fifo_do;
         end
      end
   end

   assign inst          = r_inst;
   assign rd_data       = r_rd_data;
   assign rd_data_valid = r_rd_data_valid;
   assign occupancy     = w_occ;

endmodule

// File: tb/tb_fifo_inst_encoder.sv
// Directed self-checking bench for fifo_inst_encoder.
module tb_fifo_inst_encoder;

   logic        clk;
   logic        rst;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_req;
   logic        rd_ready;
   logic [33:0] inst;
   logic [31:0] fifo_do;
   logic        fifo_read_valid;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic [4:0]  occupancy;
   logic [4:0]  outstanding;
   logic        full;
   logic        empty;
   logic        err_unexpected;

   int n_checks = 0;
   int n_errors = 0;

   fifo_inst_encoder #(.DEPTH(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .wr_valid        (wr_valid),
      .wr_data         (wr_data),
      .wr_ready        (wr_ready),
      .rd_req          (rd_req),
      .rd_ready        (rd_ready),
      .inst            (inst),
      .fifo_do         (fifo_do),
      .fifo_read_valid (fifo_read_valid),
      .rd_data         (rd_data),
      .rd_data_valid   (rd_data_valid),
      .occupancy       (occupancy),
      .outstanding     (outstanding),
      .full            (full),
      .empty           (empty),
      .err_unexpected  (err_unexpected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".inst"}, 64'(inst), 64'h0);
      check({tag, ".rd_data"}, 64'(rd_data), 64'h0);
      check({tag, ".rd_data_valid"}, 64'(rd_data_valid), 64'h0);
      check({tag, ".occupancy"}, 64'(occupancy), 64'h0);
      check({tag, ".outstanding"}, 64'(outstanding), 64'h0);
      check({tag, ".err"}, 64'(err_unexpected), 64'h0);
      check({tag, ".full"}, 64'(full), 64'h0);
      check({tag, ".empty"}, 64'(empty), 64'h1);
   endtask

   initial begin
      rst = 1'b1;
      wr_valid = 1'b0;
      wr_data = 32'h0;
      rd_req = 1'b0;
      fifo_do = 32'h0;
      fifo_read_valid = 1'b0;
      #2;
      check_reset_state("reset");
      check("reset.wr_ready", 64'(wr_ready), 64'h1);
      check("reset.rd_ready", 64'(rd_ready), 64'h0);
      step();
      rst = 1'b0;

      // Single write.
      wr_valid = 1'b1;
      wr_data = 32'hDEADBEEF;
      step();
      wr_valid = 1'b0;
      check("wr1.inst", 64'(inst), 64'h2_DEADBEEF);
      check("wr1.occ", 64'(occupancy), 64'd1);
      check("wr1.empty", 64'(empty), 64'h0);
      step();
      check("idle.inst_di_held", 64'(inst), 64'h0_DEADBEEF);

      // Single read, then its return.
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check("rd1.inst", 64'(inst), 64'h1_DEADBEEF);
      check("rd1.occ", 64'(occupancy), 64'd0);
      check("rd1.outst", 64'(outstanding), 64'd1);
      fifo_read_valid = 1'b1;
      fifo_do = 32'hDEADBEEF;
      step();
      fifo_read_valid = 1'b0;
      check("ret1.valid", 64'(rd_data_valid), 64'h1);
      check("ret1.data", 64'(rd_data), 64'hDEADBEEF);
      check("ret1.outst", 64'(outstanding), 64'd0);
      step();
      check("ret1.valid_drop", 64'(rd_data_valid), 64'h0);

      // Fill to DEPTH with 0..15.
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1;
         wr_data = 32'(i);
         step();
      end
      check("fill.inst", 64'(inst), 64'h2_0000000F);
      check("fill.occ", 64'(occupancy), 64'd16);
      check("fill.full", 64'(full), 64'h1);
      check("fill.wr_ready", 64'(wr_ready), 64'h0);

      // 17th write is held off.
      wr_data = 32'h00000100;
      step();
      check("held.inst", 64'(inst), 64'h0_0000000F);
      check("held.occ", 64'(occupancy), 64'd16);

      // Write and read together at full: only the read goes.
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check("full_rw.inst", 64'(inst), 64'h1_0000000F);
      check("full_rw.occ", 64'(occupancy), 64'd15);
      check("full_rw.outst", 64'(outstanding), 64'd1);
      step();
      wr_valid = 1'b0;
      check("full_rw.late_wr", 64'(inst), 64'h2_00000100);
      check("full_rw.occ16", 64'(occupancy), 64'd16);

      // Read alone, then both together mid-range.
      rd_req = 1'b1;
      step();
      check("rd2.occ", 64'(occupancy), 64'd15);
      wr_valid = 1'b1;
      wr_data = 32'h00000055;
      step();
      wr_valid = 1'b0;
      rd_req = 1'b0;
      check("mid_rw.inst", 64'(inst), 64'h3_00000055);
      check("mid_rw.occ", 64'(occupancy), 64'd15);
      check("mid_rw.outst", 64'(outstanding), 64'd3);

      // Return three reads: A, B, C.
      fifo_read_valid = 1'b1;
      fifo_do = 32'hA;
      step();
      check("retA.valid", 64'(rd_data_valid), 64'h1);
      check("retA.data", 64'(rd_data), 64'hA);
      check("retA.outst", 64'(outstanding), 64'd2);
      fifo_do = 32'hB;
      step();
      check("retB.data", 64'(rd_data), 64'hB);
      check("retB.outst", 64'(outstanding), 64'd1);
      fifo_do = 32'hC;
      step();
      fifo_read_valid = 1'b0;
      check("retC.valid", 64'(rd_data_valid), 64'h1);
      check("retC.data", 64'(rd_data), 64'hC);
      check("retC.outst", 64'(outstanding), 64'd0);
      check("retC.err", 64'(err_unexpected), 64'h0);
      step();
      check("ret.valid_drop", 64'(rd_data_valid), 64'h0);
      check("ret.data_hold", 64'(rd_data), 64'hC);

      // Unexpected return with nothing outstanding.
      fifo_read_valid = 1'b1;
      fifo_do = 32'h77;
      step();
      fifo_read_valid = 1'b0;
      check("unexp.err", 64'(err_unexpected), 64'h1);
      check("unexp.outst", 64'(outstanding), 64'd0);
      step();
      step();
      check("unexp.sticky", 64'(err_unexpected), 64'h1);

      // Asynchronous reset mid-stream.
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("midrst");
      step();
      rst = 1'b0;

      // At empty, read and write together: only the write goes.
      wr_valid = 1'b1;
      rd_req = 1'b1;
      wr_data = 32'h00001234;
      #1;
      check("empty_rw.rd_ready", 64'(rd_ready), 64'h0);
      step();
      wr_valid = 1'b0;
      rd_req = 1'b0;
      check("empty_rw.inst", 64'(inst), 64'h2_00001234);
      check("empty_rw.occ", 64'(occupancy), 64'd1);
      check("empty_rw.outst", 64'(outstanding), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_inst_encoder.md
Name: fifo_inst_encoder

Overview:
- Initiator side of the 34-bit FIFO instruction interface.
- Accepts a valid/ready write stream and a read-request strobe, then emits one registered instruction word per cycle, encoded as inst = {WE, RE, DI[31:0]}.
- Tracks FIFO occupancy so it never issues a write when the FIFO is full or a read when it is empty.
- Collects returned FIFO read data into an output stream and checks that every returned read was actually requested.

Parameters:
- DEPTH, 16: FIFO capacity in words; must match the SPRAM FIFO depth.
- OCC_W, $clog2(DEPTH+1): width of the occupancy and outstanding-read counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  upstream write request
- wr_data  in  32  write payload
- wr_ready  out  1  combinational; write accepted when wr_valid && wr_ready
- rd_req  in  1  read request
- rd_ready  out  1  combinational; read accepted when rd_req && rd_ready
- inst  out  34  registered instruction to the FIFO: [33]=WE, [32]=RE, [31:0]=DI
- fifo_do  in  32  FIFO read data
- fifo_read_valid  in  1  FIFO read-data strobe
- rd_data  out  32  registered read data
- rd_data_valid  out  1  one-cycle strobe qualifying rd_data
- occupancy  out  OCC_W  words committed to the FIFO
- outstanding  out  OCC_W  reads issued but not yet returned
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- err_unexpected  out  1  sticky; set when fifo_read_valid arrives with outstanding == 0

Behaviour:
- Reset (asynchronous, rst=1): all outputs are 0: inst=34'h0, rd_data=0, rd_data_valid=0, occupancy=0, outstanding=0, err_unexpected=0, full=0. empty=1.
- Reset mid-operation: all in-flight state is discarded. The environment resets the FIFO together with this block.
- Acceptance rules:
  - wr_ready = (occupancy < DEPTH).
  - rd_ready = (occupancy > 0).
- Simultaneous write and read, with 0 < occupancy < DEPTH: both are accepted. The single instruction has WE=1 and RE=1; occupancy is unchanged.
- Boundary at occupancy == DEPTH: only the read is accepted (wr_ready=0). Writes never rely on a same-cycle pop.
- Boundary at occupancy == 0: only the write is accepted (rd_ready=0). Reads never rely on same-cycle write-through.
- Encode stage, registered, latency 1:
  - On the cycle after acceptance, inst[33] = write accepted, inst[32] = read accepted.
  - inst[31:0] = wr_data if the write was accepted; otherwise it holds its previous value.
  - With no acceptance, WE=RE=0, so no operation is issued.
- Occupancy update, same edge as inst:
  - +1 on write only.
  - −1 on read only.
  - unchanged on both or neither.
  - Saturation is never reached because of the acceptance rules.
- outstanding:
  - +1 when a read is accepted.
  - −1 when fifo_read_valid is high.
  - Both in the same cycle: unchanged.
  - fifo_read_valid with outstanding == 0: err_unexpected is set (cleared only by rst) and outstanding stays 0.
- Return path, registered, latency 1:
  - rd_data_valid <= fifo_read_valid.
  - rd_data <= fifo_do when fifo_read_valid=1; otherwise rd_data holds.
  - No backpressure on rd_data; the consumer must always accept.
- Status outputs: full and empty are derived from the registered occupancy.

Decomposition:
- Shared package holds:
  - INST_W=34, DATA_W=32, WE_BIT=33, RE_BIT=32.
  - A packed inst_t struct {we, re, di}, also used by the FIFO wrapper side.
- One natural sub-module: fifo_occ_tracker (occupancy and outstanding counters, full/empty, err_unexpected).
- Encode and return registers stay in the top module.

Test Plan:
- Reset, then a single write of wr_data=32'hDEADBEEF -> next cycle inst=34'h2_DEADBEEF, occupancy=1, empty=0.
- 16 back-to-back writes of 0..15 -> wr_ready drops after the 16th acceptance, full=1; 17th write is held with no WE in inst.
- At occupancy=16, drive wr_valid and rd_req together -> inst has RE=1, WE=0; occupancy=15; the write is accepted the following cycle.
- At occupancy=0, drive rd_req and wr_valid together -> only WE=1; occupancy=1, outstanding=0.
- Issue 3 reads; model FIFO returns 32'hA, 32'hB, 32'hC with read_valid -> rd_data_valid pulses 3 times, each one cycle after its return, with data A, B, C; outstanding returns to 0.
- Pulse fifo_read_valid with outstanding=0 -> err_unexpected=1 and stays set; assert rst mid-stream -> all outputs return to their reset values immediately.
